// File: rtl/marble_launcher.sv
// Marble board sequencer: holds blue/red reservoirs, releases one marble per
// lever trigger, times each transit and halts on catch, empty reservoir or loss.
module marble_launcher #(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4,
    parameter int TRAVEL = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_red,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_blue,
    input  logic [CNT_W-1:0] load_red,
    input  logic             trig_left,
    input  logic             trig_right,
    input  logic             intercept,
    output logic             drop_blue,
    output logic             drop_red,
    output logic [CNT_W-1:0] blue_count,
    output logic [CNT_W-1:0] red_count,
    output logic [7:0]       released,
    output logic             busy,
    output logic             halted,
    output logic             empty_fault,
    output logic             timeout,
    output logic             collision
);

    localparam int TMR_W = $clog2(TRAVEL + 1);

    typedef enum logic [1:0] {IDLE, IN_FLIGHT, HALTED} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] blue_n, red_n;
    logic [7:0]       released_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             drop_blue_n, drop_red_n;
    logic             empty_fault_n, timeout_n, collision_n;
    logic             rel_go, rel_red;

    function automatic logic [CNT_W-1:0] clamp_depth(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : v;
    endfunction

    always_comb begin
        state_n       = state;
        blue_n        = blue_count;
        red_n         = red_count;
        released_n    = released;
        timer_n       = timer;
        drop_blue_n   = 1'b0;
        drop_red_n    = 1'b0;
        empty_fault_n = empty_fault;
        timeout_n     = timeout;
        collision_n   = collision;
        rel_go        = 1'b0;
        rel_red       = 1'b0;

        case (state)
            IDLE: begin
                if (load_valid) begin
                    blue_n = clamp_depth(load_blue);
                    red_n  = clamp_depth(load_red);
                end
                if (start) begin
                    rel_go     = 1'b1;
                    rel_red    = start_red;
                    released_n = 8'd0;
                end
            end
            IN_FLIGHT: begin
                if (intercept) begin
                    state_n = HALTED;
                end else if (trig_left || trig_right) begin
                    // Simultaneous triggers: blue is served, red is dropped on the floor.
                    rel_go  = 1'b1;
                    rel_red = !trig_left;
                    if (trig_left && trig_right) collision_n = 1'b1;
                end else if (timer <= TMR_W'(1)) begin
                    timer_n   = '0;
                    timeout_n = 1'b1;
                    state_n   = HALTED;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            HALTED: begin
                if (load_valid) begin
                    blue_n  = clamp_depth(load_blue);
                    red_n   = clamp_depth(load_red);
                    state_n = IDLE;
                end
                if (load_valid || start) begin
                    empty_fault_n = 1'b0;
                    timeout_n     = 1'b0;
                    collision_n   = 1'b0;
                end
                if (start) begin
                    rel_go     = 1'b1;
                    rel_red    = start_red;
                    released_n = 8'd0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Release uses the post-load counts so a same-cycle load+start drops from the new load.
        if (rel_go) begin
            if (rel_red && red_n != '0) begin
                red_n      = red_n - CNT_W'(1);
                drop_red_n = 1'b1;
                released_n = released_n + 8'd1;
                timer_n    = TMR_W'(TRAVEL);
                state_n    = IN_FLIGHT;
            end else if (!rel_red && blue_n != '0) begin
                blue_n      = blue_n - CNT_W'(1);
                drop_blue_n = 1'b1;
                released_n  = released_n + 8'd1;
                timer_n     = TMR_W'(TRAVEL);
                state_n     = IN_FLIGHT;
            end else begin
                empty_fault_n = 1'b1;
                state_n       = HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            blue_count  <= '0;
            red_count   <= '0;
            released    <= '0;
            timer       <= '0;
            drop_blue   <= 1'b0;
            drop_red    <= 1'b0;
            empty_fault <= 1'b0;
            timeout     <= 1'b0;
            collision   <= 1'b0;
        end else begin
            state       <= state_n;
            blue_count  <= blue_n;
            red_count   <= red_n;
            released    <= released_n;
            timer       <= timer_n;
            drop_blue   <= drop_blue_n;
            drop_red    <= drop_red_n;
            empty_fault <= empty_fault_n;
            timeout     <= timeout_n;
            collision   <= collision_n;
        end
    end

    assign busy   = (state == IN_FLIGHT);
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_marble_launcher.sv
// Bench for marble_launcher: directed scenarios plus randomized traffic, all
// outputs compared every cycle against an event-level reference model.
module tb_marble_launcher;

    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int TRAVEL = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, start_red = 1'b0, load_valid = 1'b0;
    logic [CNT_W-1:0] load_blue = '0, load_red = '0;
    logic             trig_left = 1'b0, trig_right = 1'b0, intercept = 1'b0;
    logic             drop_blue, drop_red, busy, halted, empty_fault, timeout, collision;
    logic [CNT_W-1:0] blue_count, red_count;
    logic [7:0]       released;

    always #5 clk = ~clk;

    marble_launcher #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TRAVEL(TRAVEL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_red(start_red),
        .load_valid(load_valid), .load_blue(load_blue), .load_red(load_red),
        .trig_left(trig_left), .trig_right(trig_right), .intercept(intercept),
        .drop_blue(drop_blue), .drop_red(drop_red),
        .blue_count(blue_count), .red_count(red_count), .released(released),
        .busy(busy), .halted(halted), .empty_fault(empty_fault),
        .timeout(timeout), .collision(collision)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 marble in flight, 2 halted.
    int m_mode, m_blue, m_red, m_rel, m_drop_edge, edge_no;
    bit m_db, m_dr, m_ef, m_to, m_col;

    task automatic model_reset();
        m_mode = 0; m_blue = 0; m_red = 0; m_rel = 0;
        m_db = 0; m_dr = 0; m_ef = 0; m_to = 0; m_col = 0;
    endtask

    function automatic int clip(input int v);
        return (v > DEPTH) ? DEPTH : v;
    endfunction

    task automatic model_release(input bit red);
        if (red ? (m_red > 0) : (m_blue > 0)) begin
            if (red) begin m_red--; m_dr = 1; end
            else     begin m_blue--; m_db = 1; end
            m_rel = (m_rel + 1) % 256;
            m_drop_edge = edge_no;
            m_mode = 1;
        end else begin
            m_ef = 1;
            m_mode = 2;
        end
    endtask

    task automatic model_edge(input bit st, input bit sr, input bit lv, input int lb, input int lr,
                              input bit tl, input bit tr, input bit ic);
        edge_no++;
        m_db = 0; m_dr = 0;
        case (m_mode)
            0: begin
                if (lv) begin m_blue = clip(lb); m_red = clip(lr); end
                if (st) begin m_rel = 0; model_release(sr); end
            end
            1: begin
                if (ic) m_mode = 2;
                else if (tl || tr) begin
                    if (tl && tr) m_col = 1;
                    model_release(!tl);
                end else if (edge_no - m_drop_edge >= TRAVEL) begin
                    m_to = 1;
                    m_mode = 2;
                end
            end
            default: begin
                if (lv) begin
                    m_blue = clip(lb); m_red = clip(lr);
                    m_ef = 0; m_to = 0; m_col = 0;
                    m_mode = 0;
                end
                if (st) begin
                    m_ef = 0; m_to = 0; m_col = 0;
                    m_rel = 0;
                    model_release(sr);
                end
            end
        endcase
    endtask

    task automatic check_all(input string where);
        check_eq({where, ".drop_blue"},   32'(drop_blue),   32'(m_db));
        check_eq({where, ".drop_red"},    32'(drop_red),    32'(m_dr));
        check_eq({where, ".blue_count"},  32'(blue_count),  32'(m_blue));
        check_eq({where, ".red_count"},   32'(red_count),   32'(m_red));
        check_eq({where, ".released"},    32'(released),    32'(m_rel));
        check_eq({where, ".busy"},        32'(busy),        32'(m_mode == 1));
        check_eq({where, ".halted"},      32'(halted),      32'(m_mode == 2));
        check_eq({where, ".empty_fault"}, 32'(empty_fault), 32'(m_ef));
        check_eq({where, ".timeout"},     32'(timeout),     32'(m_to));
        check_eq({where, ".collision"},   32'(collision),   32'(m_col));
    endtask

    // Called at a negedge: drive inputs, let one active edge pass, check at the next negedge.
    task automatic step(input string where, input bit st, input bit sr, input bit lv,
                        input int lb, input int lr, input bit tl, input bit tr, input bit ic);
        start = st; start_red = sr; load_valid = lv;
        load_blue = CNT_W'(lb); load_red = CNT_W'(lr);
        trig_left = tl; trig_right = tr; intercept = ic;
        @(posedge clk);
        model_edge(st, sr, lv, lb, lr, tl, tr, ic);
        @(negedge clk);
        check_all(where);
    endtask

    task automatic idle_step(input string where);
        step(where, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mid_cycle_reset(input string where);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all(where);
        @(negedge clk);
        check_all({where, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        edge_no = 0;
        m_drop_edge = 0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: load and first blue drop
        step("t1_load", 0, 0, 1, 3, 2, 0, 0, 0);
        step("t1_start", 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t1_drop_blue", 32'(drop_blue), 32'd1);
        check_eq("t1_blue_count", 32'(blue_count), 32'd2);
        check_eq("t1_released", 32'(released), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);

        // 2: triggers, then exhaust blue
        step("t2_tr", 0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("t2_drop_red", 32'(drop_red), 32'd1);
        idle_step("t2_gap");
        step("t2_tl1", 0, 0, 0, 0, 0, 1, 0, 0);
        step("t2_tl2", 0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("t2_blue_final", 32'(blue_count), 32'd0);
        check_eq("t2_red_final", 32'(red_count), 32'd1);
        check_eq("t2_released", 32'(released), 32'd4);
        step("t2_empty", 0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("t2_empty_fault", 32'(empty_fault), 32'd1);
        check_eq("t2_halted", 32'(halted), 32'd1);
        check_eq("t2_no_drop", 32'(drop_blue), 32'd0);

        // 3: collision and intercept priority
        step("t3_load", 0, 0, 1, 4, 4, 0, 0, 0);
        step("t3_start", 1, 0, 0, 0, 0, 0, 0, 0);
        step("t3_both", 0, 0, 0, 0, 0, 1, 1, 0);
        check_eq("t3_drop_red_blocked", 32'(drop_red), 32'd0);
        check_eq("t3_collision", 32'(collision), 32'd1);
        check_eq("t3_red_unchanged", 32'(red_count), 32'd4);
        step("t3_icpt", 0, 0, 0, 0, 0, 1, 0, 1);
        check_eq("t3_icpt_halted", 32'(halted), 32'd1);
        check_eq("t3_icpt_no_drop", 32'(drop_blue), 32'd0);

        // 4: transit timeout exactly TRAVEL cycles after the drop
        step("t4_loadstart", 1, 0, 1, 4, 4, 0, 0, 0);
        check_eq("t4_drop", 32'(drop_blue), 32'd1);
        check_eq("t4_collision_clr", 32'(collision), 32'd0);
        for (int i = 1; i <= TRAVEL; i++) begin
            idle_step("t4_wait");
            if (i == TRAVEL - 1) check_eq("t4_not_yet", 32'(timeout), 32'd0);
        end
        check_eq("t4_timeout", 32'(timeout), 32'd1);
        check_eq("t4_halted", 32'(halted), 32'd1);
        step("t4_restart", 1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t4_re_drop", 32'(drop_red), 32'd1);
        check_eq("t4_re_released", 32'(released), 32'd1);
        check_eq("t4_timeout_clr", 32'(timeout), 32'd0);

        // 5: load clamp and empty red at start
        step("t5_icpt", 0, 0, 0, 0, 0, 0, 0, 1);
        step("t5_load", 0, 0, 1, 15, 0, 0, 0, 0);
        check_eq("t5_clamp", 32'(blue_count), 32'(DEPTH));
        step("t5_start_red", 1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t5_empty_fault", 32'(empty_fault), 32'd1);
        check_eq("t5_no_drop_red", 32'(drop_red), 32'd0);

        // 6: reset while drop_red is high
        step("t6_load", 0, 0, 1, 2, 2, 0, 0, 0);
        step("t6_start", 1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t6_drop_red", 32'(drop_red), 32'd1);
        mid_cycle_reset("t6_rst");
        step("t6_trig_idle", 0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("t6_ignored", 32'(drop_blue), 32'd0);

        // Randomized traffic, alternating busy and quiet trigger phases.
        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            bit st, sr, lv, tl, tr, ic;
            int lb, lr;
            quiet = ((i / 150) % 2) == 1;
            st = ($urandom_range(0, 11) == 0);
            sr = 1'($urandom);
            lv = ($urandom_range(0, 9) == 0);
            lb = $urandom_range(0, 15);
            lr = $urandom_range(0, 15);
            tl = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            tr = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            ic = ($urandom_range(0, 29) == 0);
            step("rnd", st, sr, lv, lb, lr, tl, tr, ic);
            if ($urandom_range(0, 299) == 0) mid_cycle_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/marble_launcher.md
Name: marble_launcher

Overview:
- Sequencer for the marble board. It holds blue and red reservoir counts and drops one marble per lever trigger into the top of the cell array.
- It times each marble's transit and halts on an interceptor catch, an empty reservoir, or a lost marble.
- It sits between the board's bottom levers and its top entry. Its drop outputs drive the i_left/i_right inputs of the entry cells, and the levers feed back trig_left/trig_right.

Parameters:
DEPTH, 8, reservoir capacity per colour (1..255)
CNT_W, 4, reservoir count width; must satisfy 2**CNT_W > DEPTH
TRAVEL, 16, max cycles allowed from a drop to the next trigger/intercept (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a run
start_red  input  1  sampled with start: 0 = first marble blue, 1 = red
load_valid  input  1  reservoir load strobe
load_blue  input  CNT_W  blue count to load
load_red  input  CNT_W  red count to load
trig_left  input  1  left lever hit; request a blue marble
trig_right  input  1  right lever hit; request a red marble
intercept  input  1  marble caught by interceptor; end of run
drop_blue  output  1  one-cycle pulse: blue marble released (left entry)
drop_red  output  1  one-cycle pulse: red marble released (right entry)
blue_count  output  CNT_W  blue marbles remaining
red_count  output  CNT_W  red marbles remaining
released  output  8  marbles dropped since the last start, wraps 255->0
busy  output  1  run in progress (IN_FLIGHT)
halted  output  1  run ended; stays set until start or load
empty_fault  output  1  sticky: a requested colour had count 0
timeout  output  1  sticky: TRAVEL expired with no trigger/intercept
collision  output  1  sticky: trig_left and trig_right in the same cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE. Counts 0, released 0, timer 0. All 1-bit outputs 0.
- States: IDLE, IN_FLIGHT, HALTED. All outputs are registered. drop_* is high for exactly one cycle.
- Release action (internal, applies to chosen colour C):
  - If count_C > 0: at the next edge, drop_C=1, count_C decrements, released increments, timer loads TRAVEL, state becomes IN_FLIGHT. The decremented count is visible in the same cycle that drop_C is high.
  - If count_C == 0: no drop. At the next edge, empty_fault=1 and state becomes HALTED.
- Latency: start or trigger at edge N -> drop at cycle N+1.
- IDLE:
  - load_valid: each count <= min(load value, DEPTH).
  - start: release action with C = start_red ? red : blue. released is reset to 0 before the increment, so the first drop shows released=1.
  - Triggers and intercept are ignored.
  - load_valid together with start: the load applies first, and the release uses the loaded count.
- IN_FLIGHT (busy=1):
  - Each cycle with no event, timer decrements.
  - Event priority per cycle: intercept > trigger > timer expiry.
  - intercept: state HALTED, halted=1, busy=0, no drop.
  - trig_left alone -> release blue. trig_right alone -> release red.
  - Both triggers in one cycle: blue wins, red is discarded, collision=1.
  - The timer reaching 0 with no event: timeout=1, state HALTED.
  - start and load_valid are ignored.
- HALTED (halted=1, busy=0):
  - Triggers and intercept are ignored.
  - load_valid: loads counts (same clamp as IDLE), clears halted and the three sticky flags, returns to IDLE.
  - start: clears halted and the sticky flags, then performs the release action as from IDLE.
  - load_valid together with start: load applies first, then start.
- Counts never underflow and never exceed DEPTH. released wraps modulo 256.
- rst_n asserted mid-flight: immediate return to reset values. Any drop pulse in progress is cut.

Test Plan:
1. Reset, load_blue=3, load_red=2, start with start_red=0 -> drop_blue one cycle later, blue_count=2, released=1, busy=1.
2. Then trig_right, trig_left, trig_left on separate cycles -> drop_red, drop_blue, drop_blue each one cycle after its trigger. Final counts blue=0, red=1, released=4. A further trig_left -> empty_fault=1, halted=1, no drop.
3. In flight, assert trig_left and trig_right together -> only drop_blue, collision=1, red_count unchanged. Intercept plus trig_left in the same cycle -> halted=1, no drop.
4. After a drop with TRAVEL=16, send no trigger -> timeout=1 and halted=1 exactly 16 cycles after the drop cycle. Then start -> flags cleared, a new drop occurs, released=1.
5. load_blue=15 with DEPTH=8 -> blue_count=8. start with start_red=1 and red_count=0 -> empty_fault=1, no drop_red.
6. Drop rst_n low during IN_FLIGHT, the same cycle as drop_red=1 -> all outputs 0 immediately. After release, trig_left is ignored in IDLE.
